// File: rtl/sample_ntt_rej_pkg.sv
// Shared constants and types for the ML-KEM SampleNTT rejection sampler.
package sample_ntt_rej_pkg;

  localparam int unsigned KYBER_Q    = 3329;
  localparam int unsigned KYBER_N    = 256;
  localparam int unsigned RATE_WORDS = 21;  // 64-bit words per SHAKE128 rate block
  localparam int unsigned BUF_BYTES  = 10;  // 2 residual bytes + one 8-byte word

  typedef logic [11:0] coeff_t;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } sampler_state_e;

endpackage

// File: rtl/sample_ntt_parse.sv
// Splits three XOF bytes into two 12-bit candidates and flags those below q.
module sample_ntt_parse
  import sample_ntt_rej_pkg::*;
(
  input  logic [23:0] bytes_i,  // b0 = [7:0], b1 = [15:8], b2 = [23:16]
  output logic [11:0] d1_o,
  output logic [11:0] d2_o,
  output logic        acc1_o,
  output logic        acc2_o
);

  // d1 = b0 + 256*(b1 & 0xF), d2 = (b1 >> 4) + 16*b2
  assign d1_o   = bytes_i[11:0];
  assign d2_o   = bytes_i[23:12];
  assign acc1_o = (d1_o < 12'(KYBER_Q));
  assign acc2_o = (d2_o < 12'(KYBER_Q));

endmodule

// File: rtl/sample_ntt_rej.sv
// SampleNTT rejection sampler: byte buffer fed by 64-bit XOF words, 3-byte parse per cycle,
// up to two accepted coefficients per cycle on a registered output stage.
module sample_ntt_rej
  import sample_ntt_rej_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        xof_vld_i,
  input  logic [63:0] xof_data_i,
  output logic        xof_rdy_o,
  output logic        squeeze_o,
  output logic [1:0]  coeff_vld_o,
  output logic [23:0] coeff_o,
  output logic [7:0]  coeff_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned BufW = 8 * BUF_BYTES;

  sampler_state_e  state_q, state_d;
  logic [BufW-1:0] buf_q, buf_d, buf_sh;
  logic [3:0]      cnt_q, cnt_d, cnt_ap;
  logic [8:0]      j_q, j_d, j_mid, j_nxt;
  logic [4:0]      w_q, w_d;
  logic [1:0]      vld_q, vld_d;
  logic [23:0]     coeff_q, coeff_d;
  logic [7:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic            squeeze_q, squeeze_d;

  logic            parse_en, load, acc1, acc2, p_acc1, p_acc2;
  coeff_t          d1, d2;

  sample_ntt_parse u_parse (
    .bytes_i (buf_q[23:0]),
    .d1_o    (d1),
    .d2_o    (d2),
    .acc1_o  (p_acc1),
    .acc2_o  (p_acc2)
  );

  // Parse/load handshake and acceptance qualification against the coefficient budget.
  always_comb begin
    parse_en  = (state_q == StRun) && (cnt_q >= 4'd3) && !start_i;
    cnt_ap    = (cnt_q >= 4'd3) ? cnt_q - 4'd3 : cnt_q;
    buf_sh    = parse_en ? (buf_q >> 24) : buf_q;
    xof_rdy_o = (state_q == StRun) && (cnt_ap <= 4'd2);
    load      = xof_vld_i && xof_rdy_o;
    acc1      = parse_en && p_acc1 && (j_q < 9'(KYBER_N));
    j_mid     = j_q + {8'd0, acc1};
    acc2      = parse_en && p_acc2 && (j_mid < 9'(KYBER_N));
    j_nxt     = j_mid + {8'd0, acc2};
  end

  // Next-state: FSM, buffer shift/append, counters and output stage.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    w_d       = w_q;
    vld_d     = 2'b00;
    coeff_d   = '0;
    idx_d     = '0;
    done_d    = 1'b0;
    squeeze_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          buf_d   = '0;
          cnt_d   = '0;
          j_d     = '0;
          w_d     = '0;
        end
      end
      StRun: begin
        if (start_i) begin
          buf_d = '0;
          cnt_d = '0;
          j_d   = '0;
          w_d   = '0;
        end else begin
          // New word lands right behind whatever residual bytes survive this parse.
          buf_d = buf_sh | (load ? ({16'h0, xof_data_i} << {cnt_ap, 3'b000}) : '0);
          cnt_d = cnt_ap + (load ? 4'd8 : 4'd0);
          j_d   = j_nxt;
          vld_d = {acc1 && acc2, acc1 || acc2};
          // A lone accepted value always rides on lane0.
          if (acc1) begin
            coeff_d[11:0] = d1;
            if (acc2) coeff_d[23:12] = d2;
          end else if (acc2) begin
            coeff_d[11:0] = d2;
          end
          if (acc1 || acc2) idx_d = j_q[7:0];
          if (load) begin
            w_d       = (w_q == 5'(RATE_WORDS - 1)) ? 5'd0 : w_q + 5'd1;
            squeeze_d = (w_q == 5'(RATE_WORDS - 1)) && (j_nxt != 9'(KYBER_N));
          end
          if (j_nxt == 9'(KYBER_N)) begin
            done_d  = 1'b1;
            state_d = StIdle;
            buf_d   = '0;
            cnt_d   = '0;
            w_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      buf_q     <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      w_q       <= '0;
      vld_q     <= '0;
      coeff_q   <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      squeeze_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      w_q       <= w_d;
      vld_q     <= vld_d;
      coeff_q   <= coeff_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      squeeze_q <= squeeze_d;
    end
  end

  assign coeff_vld_o = vld_q;
  assign coeff_o     = coeff_q;
  assign coeff_idx_o = idx_q;
  assign done_o      = done_q;
  assign squeeze_o   = squeeze_q;
  assign busy_o      = (state_q == StRun);

endmodule

// File: tb/tb_sample_ntt_rej.sv
// Directed self-checking bench for the SampleNTT rejection sampler.
module tb_sample_ntt_rej;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        xof_vld = 1'b0;
  logic [63:0] xof_data = '0;
  logic        xof_rdy_o, squeeze_o, busy_o, done_o;
  logic [1:0]  coeff_vld_o;
  logic [23:0] coeff_o;
  logic [7:0]  coeff_idx_o;

  sample_ntt_rej dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .xof_vld_i   (xof_vld),
    .xof_data_i  (xof_data),
    .xof_rdy_o   (xof_rdy_o),
    .squeeze_o   (squeeze_o),
    .coeff_vld_o (coeff_vld_o),
    .coeff_o     (coeff_o),
    .coeff_idx_o (coeff_idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  vld;
    logic [11:0] c0;
    logic [11:0] c1;
    logic [7:0]  idx;
    logic        done;
    logic        busy;
  } beat_t;

  beat_t beats[$];
  int    sq_cyc[$];
  int    acc_cyc[$];
  int    cyc = 0;
  int    done_seen = 0;
  int    n_pass = 0;
  int    n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (coeff_vld_o != 2'b00) begin
        b.vld  = coeff_vld_o;
        b.c0   = coeff_o[11:0];
        b.c1   = coeff_o[23:12];
        b.idx  = coeff_idx_o;
        b.done = done_o;
        b.busy = busy_o;
        beats.push_back(b);
      end
      if (done_o) done_seen++;
      if (squeeze_o) sq_cyc.push_back(cyc);
    end
  end

  function automatic beat_t get_beat(input int i);
    if (i < beats.size()) return beats[i];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one word and hold it until accepted; returns at the negedge after acceptance.
  task automatic send_word(input logic [63:0] wd);
    int n = 0;
    xof_vld  = 1'b1;
    xof_data = wd;
    #1;
    while (!xof_rdy_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rdy_wait", 32'(n < 100), 32'd1);
    acc_cyc.push_back(cyc);
    @(posedge clk);
    @(negedge clk);
    xof_vld = 1'b0;
  endtask

  logic [7:0]  stream [392];
  logic [63:0] wd;
  beat_t       bt;
  int          b0, sq0, a0, d0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(xof_rdy_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_squeeze", 32'(squeeze_o), 0);
    chk("rst_vld", 32'(coeff_vld_o), 0);
    chk("rst_coeff", 32'(coeff_o), 0);
    chk("rst_idx", 32'(coeff_idx_o), 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Bytes 01 00 00 | 00 0D D0 | FF FF
    pulse_start();
    chk("start_busy", 32'(busy_o), 1);
    chk("start_rdy", 32'(xof_rdy_o), 1);
    b0 = beats.size();
    send_word(64'hFFFF_D00D_0000_0001);
    chk("lat_parse_cycle", 32'(coeff_vld_o), 0);
    @(negedge clk);
    chk("lat_first_beat", 32'(coeff_vld_o), 3);
    repeat (3) @(negedge clk);
    chk("t1_nbeats", 32'(beats.size() - b0), 2);
    bt = get_beat(b0);
    chk("t1_b0_vld", 32'(bt.vld), 3);
    chk("t1_b0_c0", 32'(bt.c0), 1);
    chk("t1_b0_c1", 32'(bt.c1), 0);
    chk("t1_b0_idx", 32'(bt.idx), 0);
    bt = get_beat(b0 + 1);
    chk("t1_b1_vld", 32'(bt.vld), 3);
    chk("t1_b1_c0", 32'(bt.c0), 3328);
    chk("t1_b1_c1", 32'(bt.c1), 3328);
    chk("t1_b1_idx", 32'(bt.idx), 2);
    chk("t1_rdy_resid2", 32'(xof_rdy_o), 1);
    chk("t1_busy", 32'(busy_o), 1);

    // Restart mid-run; bytes 01 0D D0 then all-FF rejects
    pulse_start();
    b0 = beats.size();
    send_word(64'hFFFF_FFFF_FFD0_0D01);
    chk("t2_rdy_cnt8", 32'(xof_rdy_o), 0);
    repeat (4) @(negedge clk);
    chk("t2_nbeats", 32'(beats.size() - b0), 1);
    bt = get_beat(b0);
    chk("t2_vld", 32'(bt.vld), 1);
    chk("t2_c0", 32'(bt.c0), 3328);
    chk("t2_idx", 32'(bt.idx), 0);
    send_word(64'hFFFF_FFFF_FFFF_FFFF);
    chk("t2_rdy_cnt10", 32'(xof_rdy_o), 0);
    @(negedge clk);
    chk("t2_rdy_cnt7", 32'(xof_rdy_o), 0);
    @(negedge clk);
    chk("t2_rdy_cnt4", 32'(xof_rdy_o), 1);
    @(negedge clk);
    chk("t2_rdy_cnt1", 32'(xof_rdy_o), 1);
    repeat (2) @(negedge clk);
    chk("t2_no_new_beats", 32'(beats.size() - b0), 1);
    send_word(64'h0);
    repeat (5) @(negedge clk);
    chk("t2_nbeats_after", 32'(beats.size() - b0), 4);
    bt = get_beat(b0 + 1);
    chk("t2_resume_vld", 32'(bt.vld), 3);
    chk("t2_resume_c0", 32'(bt.c0), 255);
    chk("t2_resume_idx", 32'(bt.idx), 1);

    // Full polynomial: 127 zero pairs, 7 alone at 254, then (5,6) with only 5 kept
    for (int k = 0; k < 392; k++) stream[k] = 8'h00;
    stream[381] = 8'h07; stream[382] = 8'h00; stream[383] = 8'hFF;
    stream[384] = 8'h05; stream[385] = 8'h60; stream[386] = 8'h00;
    pulse_start();
    b0  = beats.size();
    sq0 = sq_cyc.size();
    a0  = acc_cyc.size();
    d0  = done_seen;
    for (int w = 0; w < 49; w++) begin
      for (int k = 0; k < 8; k++) wd[8*k +: 8] = stream[8*w + k];
      send_word(wd);
    end
    repeat (6) @(negedge clk);
    chk("t3_nbeats", 32'(beats.size() - b0), 129);
    bt = get_beat(b0 + 126);
    chk("t3_252_vld", 32'(bt.vld), 3);
    chk("t3_252_idx", 32'(bt.idx), 252);
    bt = get_beat(b0 + 127);
    chk("t3_254_vld", 32'(bt.vld), 1);
    chk("t3_254_c0", 32'(bt.c0), 7);
    chk("t3_254_idx", 32'(bt.idx), 254);
    bt = get_beat(b0 + 128);
    chk("t3_255_vld", 32'(bt.vld), 1);
    chk("t3_255_c0", 32'(bt.c0), 5);
    chk("t3_255_c1", 32'(bt.c1), 0);
    chk("t3_255_idx", 32'(bt.idx), 255);
    chk("t3_255_done", 32'(bt.done), 1);
    chk("t3_255_busy", 32'(bt.busy), 0);
    chk("t3_done_count", 32'(done_seen - d0), 1);
    chk("t3_idle_rdy", 32'(xof_rdy_o), 0);
    chk("t3_idle_busy", 32'(busy_o), 0);
    chk("t3_squeeze_count", 32'(sq_cyc.size() - sq0), 2);
    chk("t3_squeeze1_time",
        32'((sq_cyc.size() > sq0) ? sq_cyc[sq0] : -1),
        32'((acc_cyc.size() > a0 + 20) ? acc_cyc[a0 + 20] + 1 : -2));
    chk("t3_squeeze2_time",
        32'((sq_cyc.size() > sq0 + 1) ? sq_cyc[sq0 + 1] : -1),
        32'((acc_cyc.size() > a0 + 41) ? acc_cyc[a0 + 41] + 1 : -2));

    // Asynchronous reset mid-run, then clean restart
    pulse_start();
    d0 = done_seen;
    send_word(64'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(coeff_vld_o), 0);
    chk("arst_coeff", 32'(coeff_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_rdy", 32'(xof_rdy_o), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    b0 = beats.size();
    send_word(64'hFFFF_D00D_0000_0001);
    repeat (4) @(negedge clk);
    bt = get_beat(b0);
    chk("arst_restart_vld", 32'(bt.vld), 3);
    chk("arst_restart_c0", 32'(bt.c0), 1);
    chk("arst_restart_idx", 32'(bt.idx), 0);
    chk("arst_no_done", 32'(done_seen - d0), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
